// File: rtl/sync_addsub_acc_pkg.sv
// Shared opcode encoding and widths for the add/subtract accumulator
// and for the board top-levels that drive it.
package sync_addsub_acc_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

endpackage

// File: rtl/sync_addsub_acc_if.sv
// Operation request and result bundle for sync_addsub_acc.
// in_valid qualifies op/acc_mode/opA/opB for exactly one cycle; there is no
// backpressure, so every in_valid cycle is accepted, and out_valid pulses
// for exactly one cycle per accepted op with result/carry/overflow valid.
interface sync_addsub_acc_if
  import sync_addsub_acc_pkg::*;
#(
  parameter int W = 4
);
  logic            in_valid;
  logic [OP_W-1:0] op;
  logic            acc_mode;
  logic [W-1:0]    opA;
  logic [W-1:0]    opB;
  logic [W-1:0]    result;
  logic            carry;
  logic            overflow;
  logic            ovf_sticky;
  logic            out_valid;

  modport master (
    output in_valid, op, acc_mode, opA, opB,
    input  result, carry, overflow, ovf_sticky, out_valid
  );

  modport slave (
    input  in_valid, op, acc_mode, opA, opB,
    output result, carry, overflow, ovf_sticky, out_valid
  );
endinterface

// File: rtl/sync_addsub_acc_core.sv
// Combinational W-bit add/subtract: carry-out and two's-complement overflow.
module sync_addsub_acc_core #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry,
  output logic         overflow
);

  logic [W-1:0] b_eff;
  logic [W:0]   full;

  // Subtraction is A + ~B + 1, so carry-out reads as "no borrow".
  assign b_eff    = sub ? ~b : b;
  assign full     = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
  assign sum      = full[W-1:0];
  assign carry    = full[W];
  assign overflow = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/sync_addsub_acc.sv
// Two-stage add/subtract unit with accumulator, optional saturation and
// sticky overflow; S1 captures the request, S2 computes and updates outputs.
module sync_addsub_acc
  import sync_addsub_acc_pkg::*;
#(
  parameter int W   = 4,
  parameter bit SAT = 1'b0
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  sync_addsub_acc_if.slave  bus
);

  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic         s1_valid;
  op_e          s1_op;
  logic         s1_acc_mode;
  logic [W-1:0] s1_a;
  logic [W-1:0] s1_b;

  logic [W-1:0] acc;
  logic [W-1:0] result_q;
  logic         carry_q;
  logic         overflow_q;
  logic         sticky_q;
  logic         out_valid_q;

  logic [W-1:0] a_sel;
  logic [W-1:0] core_sum;
  logic         core_carry;
  logic         core_ovf;
  logic [W-1:0] nxt_result;
  logic         nxt_carry;
  logic         nxt_ovf;

  // The accumulator is only touched in S2, so chained acc_mode ops see
  // the previous op's result without any forwarding path.
  assign a_sel = s1_acc_mode ? acc : s1_a;

  sync_addsub_acc_core #(.W(W)) u_core (
    .a        (a_sel),
    .b        (s1_b),
    .sub      (s1_op == OP_SUB),
    .sum      (core_sum),
    .carry    (core_carry),
    .overflow (core_ovf)
  );

  always_comb begin
    nxt_result = core_sum;
    nxt_carry  = core_carry;
    nxt_ovf    = core_ovf;
    case (s1_op)
      OP_ADD, OP_SUB: begin
        // On signed overflow the true result lies beyond A's side of the range.
        if (SAT && core_ovf) begin
          nxt_result = a_sel[W-1] ? SAT_MIN : SAT_MAX;
        end
      end
      OP_LOAD: begin
        nxt_result = s1_b;
        nxt_carry  = 1'b0;
        nxt_ovf    = 1'b0;
      end
      OP_CLEAR: begin
        nxt_result = '0;
        nxt_carry  = 1'b0;
        nxt_ovf    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_op       <= OP_ADD;
      s1_acc_mode <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      acc         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s1_valid    <= bus.in_valid;
      s1_op       <= op_e'(bus.op);
      s1_acc_mode <= bus.acc_mode;
      s1_a        <= bus.opA;
      s1_b        <= bus.opB;
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        acc        <= nxt_result;
        result_q   <= nxt_result;
        carry_q    <= nxt_carry;
        overflow_q <= nxt_ovf;
        if (s1_op == OP_CLEAR) begin
          sticky_q <= 1'b0;
        end else if (nxt_ovf) begin
          sticky_q <= 1'b1;
        end
      end
    end
  end

  assign bus.result     = result_q;
  assign bus.carry      = carry_q;
  assign bus.overflow   = overflow_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_sync_addsub_acc.sv
// Bench for sync_addsub_acc: three instances (W=4 wrap, W=4 saturate, W=8 wrap)
// driven in lockstep and checked against an arithmetic reference model.
module tb_sync_addsub_acc;
  import sync_addsub_acc_pkg::*;

  localparam int EW = 36;

  logic CLOCK_50;
  logic reset;

  sync_addsub_acc_if #(.W(4)) if0 ();
  sync_addsub_acc_if #(.W(4)) if1 ();
  sync_addsub_acc_if #(.W(8)) if2 ();

  sync_addsub_acc #(.W(4), .SAT(1'b0)) dut0 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(if0));
  sync_addsub_acc #(.W(4), .SAT(1'b1)) dut1 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(if1));
  sync_addsub_acc #(.W(8), .SAT(1'b0)) dut2 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(if2));

  // clock / reset
  initial begin
    CLOCK_50 = 1'b0;
    forever #10 CLOCK_50 = ~CLOCK_50;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  int wid [3] = '{4, 4, 8};
  bit sat [3] = '{1'b0, 1'b1, 1'b0};
  int m_acc [3];
  int m_res [3];
  bit m_c   [3];
  bit m_o   [3];
  bit m_st  [3];
  bit m_v   [3];

  task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      m_acc[ch] = 0; m_res[ch] = 0; m_c[ch] = 0; m_o[ch] = 0; m_st[ch] = 0; m_v[ch] = 0;
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  task automatic model_step(input int ch, input bit v, input logic [1:0] op, input bit am,
                            input logic [7:0] a, input logic [7:0] b, output logic [11:0] e);
    int span, ua, ub, sa, sb, r, s, res;
    bit c, o;
    span = 1 << wid[ch];
    if (v) begin
      ua = am ? m_acc[ch] : int'(a) % span;
      ub = int'(b) % span;
      sa = (ua >= span / 2) ? ua - span : ua;
      sb = (ub >= span / 2) ? ub - span : ub;
      res = 0; c = 0; o = 0;
      if (op == OP_ADD || op == OP_SUB) begin
        if (op == OP_ADD) begin
          r = ua + ub; c = (r >= span); s = sa + sb;
        end else begin
          r = ua - ub; c = (ua >= ub); s = sa - sb;
        end
        o = (s >= span / 2) || (s < -(span / 2));
        res = ((r % span) + span) % span;
        if (sat[ch] && o) res = (sa >= 0) ? span / 2 - 1 : span / 2;
      end else if (op == OP_LOAD) begin
        res = ub;
      end
      m_acc[ch] = res; m_res[ch] = res; m_c[ch] = c; m_o[ch] = o;
      m_st[ch] = (op == OP_CLEAR) ? 1'b0 : (m_st[ch] | o);
      m_v[ch] = 1'b1;
    end else begin
      m_v[ch] = 1'b0;
    end
    e = {m_v[ch], m_st[ch], m_o[ch], m_c[ch], 8'(m_res[ch])};
  endtask

  function automatic logic [EW-1:0] dut_pack();
    return {if2.out_valid, if2.ovf_sticky, if2.overflow, if2.carry, if2.result,
            if1.out_valid, if1.ovf_sticky, if1.overflow, if1.carry, 4'b0, if1.result,
            if0.out_valid, if0.ovf_sticky, if0.overflow, if0.carry, 4'b0, if0.result};
  endfunction

  // driver: one cycle, called at a falling edge, returns at the next falling edge
  task automatic cycle(input bit rst_i, input bit v, input logic [1:0] op_i, input bit am,
                       input logic [7:0] a, input logic [7:0] b);
    logic [EW-1:0] e, got, old;
    logic [11:0] e_ch;
    reset = rst_i;
    if0.in_valid = v; if0.op = op_i; if0.acc_mode = am; if0.opA = a[3:0]; if0.opB = b[3:0];
    if1.in_valid = v; if1.op = op_i; if1.acc_mode = am; if1.opA = a[3:0]; if1.opB = b[3:0];
    if2.in_valid = v; if2.op = op_i; if2.acc_mode = am; if2.opA = a;      if2.opB = b;
    e = '0;
    if (!rst_i) begin
      for (int ch = 0; ch < 3; ch++) begin
        model_step(ch, v, op_i, am, a, b, e_ch);
        e[ch*12 +: 12] = e_ch;
      end
      exp_q.push_back(e);
    end
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    got = dut_pack();
    if (rst_i) begin
      exp_q.delete();
      model_reset();
      for (int ch = 0; ch < 3; ch++)
        check_eq($sformatf("reset_ch%0d", ch), EW'(got[ch*12 +: 12]), '0);
      exp_q.push_back('0);
    end else if (exp_q.size() >= 2) begin
      old = exp_q.pop_front();
      for (int ch = 0; ch < 3; ch++)
        check_eq($sformatf("sb_ch%0d", ch), EW'(got[ch*12 +: 12]), EW'(old[ch*12 +: 12]));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, OP_ADD, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    // reset, with in_valid asserted during reset
    cycle(1'b1, 1'b1, OP_ADD, 1'b0, 8'h05, 8'h03);
    cycle(1'b1, 1'b1, OP_ADD, 1'b0, 8'h05, 8'h03);
    idle();
    check_eq("rst_no_valid", EW'(if0.out_valid), 0);
    idle();
    check_eq("rst_no_valid2", EW'(if0.out_valid), 0);

    // ADD 5+3: wraps on dut0, saturates on dut1
    cycle(1'b0, 1'b1, OP_ADD, 1'b0, 8'h05, 8'h03);
    idle();
    check_eq("add53_res",    EW'(if0.result), 36'h8);
    check_eq("add53_flags",  EW'({if0.carry, if0.overflow, if0.ovf_sticky}), 36'b011);
    check_eq("add53_sat",    EW'({if1.result, if1.overflow}), EW'({4'h7, 1'b1}));

    cycle(1'b0, 1'b1, OP_SUB, 1'b0, 8'h01, 8'h01);
    idle();
    check_eq("sub11", EW'({if0.result, if0.carry, if0.overflow}), EW'({4'h0, 2'b10}));
    cycle(1'b0, 1'b1, OP_SUB, 1'b0, 8'h02, 8'h05);
    idle();
    check_eq("sub25", EW'({if0.result, if0.carry, if0.overflow}), EW'({4'hD, 2'b00}));
    cycle(1'b0, 1'b1, OP_SUB, 1'b0, 8'h08, 8'h01);
    idle();
    check_eq("sub81", EW'({if0.result, if0.carry, if0.overflow}), EW'({4'h7, 2'b11}));

    // accumulate back-to-back
    cycle(1'b0, 1'b1, OP_CLEAR, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, OP_LOAD,  1'b1, 8'h0F, 8'h03);
    cycle(1'b0, 1'b1, OP_ADD,   1'b1, 8'h0F, 8'h04);
    check_eq("acc_load", EW'(if0.result), 36'h3);
    cycle(1'b0, 1'b1, OP_ADD,   1'b1, 8'h0F, 8'h02);
    check_eq("acc_add4", EW'(if0.result), 36'h7);
    cycle(1'b0, 1'b1, OP_CLEAR, 1'b1, 8'h00, 8'h00);
    check_eq("acc_add2", EW'({if0.result, if0.overflow, if0.out_valid}), EW'({4'h9, 2'b11}));
    idle();
    check_eq("acc_clear", EW'({if0.result, if0.ovf_sticky, if0.out_valid}), EW'({4'h0, 2'b01}));

    // bubbles
    cycle(1'b0, 1'b1, OP_ADD, 1'b0, 8'h01, 8'h01);
    cycle(1'b0, 1'b0, OP_ADD, 1'b0, 8'h00, 8'h00);
    check_eq("bub_first", EW'({if0.result, if0.out_valid}), EW'({4'h2, 1'b1}));
    cycle(1'b0, 1'b1, OP_ADD, 1'b0, 8'h02, 8'h02);
    check_eq("bub_hold",  EW'({if0.result, if0.out_valid}), EW'({4'h2, 1'b0}));
    idle();
    check_eq("bub_second", EW'({if0.result, if0.out_valid}), EW'({4'h4, 1'b1}));

    // reset mid-pipeline
    cycle(1'b0, 1'b1, OP_ADD, 1'b0, 8'h06, 8'h01);
    cycle(1'b1, 1'b0, OP_ADD, 1'b0, 8'h00, 8'h00);
    idle();
    check_eq("midrst", EW'({if0.result, if0.out_valid}), 36'h0);

    // W=8 signed overflow
    cycle(1'b0, 1'b1, OP_ADD, 1'b0, 8'h7F, 8'h01);
    idle();
    check_eq("w8_add", EW'({if2.result, if2.overflow}), EW'({8'h80, 1'b1}));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
